// File: rtl/led_ctrl.sv
// Eight-LED controller: off/on/blink/pwm per LED on a shared prescaler, PWM and blink timebase.
// Define LED_CTRL_FADE_EN to ramp each active duty one step per PWM period toward its target.

module led_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [1:0] wr_mode,
  input  logic [7:0] wr_duty,
  input  logic       wrap,
  input  logic       blink_phase,
  input  logic [7:0] pwm_cnt,
  output logic       led
);
  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_BLINK = 2'b10;

  logic [1:0] mode;
  logic [7:0] shadow;
  logic [7:0] active;
  logic [7:0] active_nxt;

`ifdef LED_CTRL_FADE_EN
  always_comb begin
    active_nxt = active;
    if (shadow > active)      active_nxt = active + 8'd1;
    else if (shadow < active) active_nxt = active - 8'd1;
  end
`else
  assign active_nxt = shadow;
`endif

  // active only moves at the period boundary, so a period never mixes two duties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode   <= M_OFF;
      shadow <= 8'd0;
      active <= 8'd0;
      led    <= 1'b0;
    end else begin
      if (wrap) active <= active_nxt;
      if (wr) begin
        mode   <= wr_mode;
        shadow <= wr_duty;
      end
      case (mode)
        M_OFF:   led <= 1'b0;
        M_ON:    led <= 1'b1;
        M_BLINK: led <= blink_phase;
        default: led <= (pwm_cnt < active);
      endcase
    end
  end
endmodule

module led_ctrl #(
  parameter int PRESCALE      = 450,
  parameter int BLINK_PERIODS = 256
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] cfg_idx,
  input  logic [1:0] cfg_mode,
  input  logic [7:0] cfg_duty,
  output logic [0:7] led,
  output logic       pwm_wrap
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_PERIODS - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_COMMIT} state_t;
  typedef struct packed {
    logic [2:0] idx;
    logic [1:0] mode;
    logic [7:0] duty;
  } cfg_req_t;

  state_t          state, state_nxt;
  cfg_req_t        pend;
  logic            accept;
  logic            tick;
  logic            wrap_evt;
  logic [PW-1:0]   presc;
  logic [7:0]      pwm_cnt;
  logic [BW-1:0]   blink_cnt;
  logic            blink_phase;

  // ST_INIT holds cfg_ready low through reset and for the edge that leaves it
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_INIT: state_nxt = ST_IDLE;
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          accept    = 1'b1;
          state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) pend <= {cfg_idx, cfg_mode, cfg_duty};
    end
  end

  assign tick     = (presc == PRE_MAX);
  assign wrap_evt = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      pwm_cnt     <= 8'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pwm_wrap    <= 1'b0;
    end else begin
      presc    <= tick ? '0 : presc + PW'(1);
      pwm_wrap <= wrap_evt;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
      if (wrap_evt) begin
        if (blink_cnt == BLK_MAX) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_lane
    led_lane u_lane (
      .clk         (sys_clk),
      .rst_n       (rst_n),
      .wr          ((state == ST_COMMIT) && (pend.idx == 3'(i))),
      .wr_mode     (pend.mode),
      .wr_duty     (pend.duty),
      .wrap        (wrap_evt),
      .blink_phase (blink_phase),
      .pwm_cnt     (pwm_cnt),
      .led         (led[i])
    );
  end
endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl: directed scenarios plus random writes against an
// arithmetic reference model (timebase derived from the edge count since reset release).

module tb_led_ctrl;
  localparam int P   = 2;
  localparam int B   = 2;
  localparam int PER = 256 * P;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_idx = 3'd0;
  logic [1:0] cfg_mode = 2'd0;
  logic [7:0] cfg_duty = 8'd0;
  logic [0:7] led;
  logic       pwm_wrap;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  led_ctrl #(.PRESCALE(P), .BLINK_PERIODS(B)) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_idx   (cfg_idx),
    .cfg_mode  (cfg_mode),
    .cfg_duty  (cfg_duty),
    .led       (led),
    .pwm_wrap  (pwm_wrap)
  );

  // reference model state
  int         n;
  bit         m_ready;
  logic [1:0] m_mode [8];
  int         m_shadow [8];
  int         m_active [8];
  bit         p_vld;
  int         p_idx, p_mode, p_duty;
  logic [0:7] exp_led;
  bit         exp_wrap;

  task automatic model_reset();
    n = 0; m_ready = 0; p_vld = 0;
    for (int i = 0; i < 8; i++) begin
      m_mode[i] = 2'd0; m_shadow[i] = 0; m_active[i] = 0;
    end
  endtask

  // one clock edge; the model advances from the inputs the bench drove, then waits for negedge
  task automatic step();
    int pc, ph;
    bit acc;
    @(posedge sys_clk);
    n++;
    pc = ((n - 1) / P) % 256;
    ph = ((n - 1) / (PER * B)) % 2;
    for (int i = 0; i < 8; i++) begin
      case (m_mode[i])
        2'd0:    exp_led[i] = 1'b0;
        2'd1:    exp_led[i] = 1'b1;
        2'd2:    exp_led[i] = ph[0];
        default: exp_led[i] = (pc < m_active[i]);
      endcase
    end
    exp_wrap = ((n % PER) == 0);
    if (exp_wrap) begin
      for (int i = 0; i < 8; i++) begin
`ifdef LED_CTRL_FADE_EN
        if (m_active[i] < m_shadow[i]) m_active[i]++;
        else if (m_active[i] > m_shadow[i]) m_active[i]--;
`else
        m_active[i] = m_shadow[i];
`endif
      end
    end
    if (p_vld) begin
      m_mode[p_idx] = p_mode[1:0]; m_shadow[p_idx] = p_duty; p_vld = 0;
    end
    acc = cfg_valid && m_ready;
    if (acc) begin
      p_vld = 1; p_idx = int'(cfg_idx); p_mode = int'(cfg_mode); p_duty = int'(cfg_duty);
    end
    m_ready = !acc;
    @(negedge sys_clk);
  endtask

  task automatic do_write(input int idx, input int md, input int duty);
    while (!m_ready) step();
    cfg_valid = 1'b1; cfg_idx = idx[2:0]; cfg_mode = md[1:0]; cfg_duty = duty[7:0];
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_wrap();
    step();
    while (!exp_wrap) step();
  endtask

  task automatic count_high(input int idx, output int hi);
    hi = 0;
    for (int c = 0; c < PER; c++) begin
      step();
      if (led[idx] === 1'b1) hi++;
    end
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    cfg_valid = 1'b1; cfg_idx = 3'd2; cfg_mode = 2'b01; cfg_duty = 8'h80;
    @(posedge sys_clk); #2;
    rst_n = 1'b0; cfg_valid = 1'b0;
    #1;
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led got %b exp 00000000", led); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", cfg_ready); end
    checks++; if (pwm_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b exp 0", pwm_wrap); end
    repeat (3) begin
      @(negedge sys_clk);
      checks++; if (led !== 8'h00 || cfg_ready !== 1'b0) begin
        errors++; $display("FAIL reset_hold led %b ready %b exp 00000000 0", led, cfg_ready);
      end
    end
    rst_n = 1'b1;
    model_reset();
    step();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", cfg_ready); end
    repeat (4) step();
    checks++; if (led !== exp_led) begin errors++; $display("FAIL reset_discard led got %b exp %b", led, exp_led); end
  endtask

  task automatic test_on_write();
    do_write(0, 1, 0);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL on_ready_commit got %b exp 0", cfg_ready); end
    step();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL on_ready_back got %b exp 1", cfg_ready); end
    checks++; if (led[0] !== 1'b0) begin errors++; $display("FAIL on_led_early got %b exp 0", led[0]); end
    step();
    checks++; if (led[0] !== 1'b1) begin errors++; $display("FAIL on_led got %b exp 1", led[0]); end
  endtask

  task automatic test_fade();
    int hi, e;
    do_write(1, 3, 3);
    step();
    wait_wrap();
    for (int k = 1; k <= 4; k++) begin
      count_high(1, hi);
`ifdef LED_CTRL_FADE_EN
      e = P * ((k < 3) ? k : 3);
`else
      e = P * 3;
`endif
      checks++; if (hi !== e) begin errors++; $display("FAIL fade_period%0d high got %0d exp %0d", k, hi, e); end
    end
  endtask

  task automatic test_pwm64();
    int hi, e;
    do_write(3, 3, 64);
    step();
    wait_wrap();
    count_high(3, hi);
`ifdef LED_CTRL_FADE_EN
    e = P * 1;
`else
    e = 128;
`endif
    checks++; if (hi !== e) begin errors++; $display("FAIL pwm64 high got %0d exp %0d", hi, e); end
  endtask

  task automatic test_duty_limits();
    int h4, h6, e6;
    do_write(4, 3, 0);
    do_write(6, 3, 255);
    step();
    wait_wrap();
    h4 = 0; h6 = 0;
    for (int c = 0; c < PER; c++) begin
      step();
      if (led[4] === 1'b1) h4++;
      if (led[6] === 1'b1) h6++;
    end
`ifdef LED_CTRL_FADE_EN
    e6 = P * 1;
`else
    e6 = P * 255;
`endif
    checks++; if (h4 !== 0) begin errors++; $display("FAIL duty0 high got %0d exp 0", h4); end
    checks++; if (h6 !== e6) begin errors++; $display("FAIL duty255 high got %0d exp %0d", h6, e6); end
  endtask

  task automatic test_wrap_write();
    int h1, h2, e1, e2;
    do_write(5, 3, 10);
    step();
    wait_wrap();
    wait_wrap();
    while (!(((n + 1) % PER) == 0 && m_ready)) step();
    cfg_valid = 1'b1; cfg_idx = 3'd5; cfg_mode = 2'b11; cfg_duty = 8'd200;
    step();
    cfg_valid = 1'b0;
    checks++; if (pwm_wrap !== 1'b1 || cfg_ready !== 1'b0) begin
      errors++; $display("FAIL wrap_write_accept wrap %b ready %b exp 1 0", pwm_wrap, cfg_ready);
    end
`ifdef LED_CTRL_FADE_EN
    e1 = P * m_active[5];
    e2 = P * (m_active[5] + 1);
`else
    e1 = P * 10;
    e2 = P * 200;
`endif
    count_high(5, h1);
    count_high(5, h2);
    checks++; if (h1 !== e1) begin errors++; $display("FAIL wrap_write_old high got %0d exp %0d", h1, e1); end
    checks++; if (h2 !== e2) begin errors++; $display("FAIL wrap_write_new high got %0d exp %0d", h2, e2); end
  endtask

  task automatic test_blink();
    int tog, t0, t1, t2;
    logic prev;
    do_write(7, 2, 0);
    repeat (1100) step();
    prev = led[7]; tog = 0; t0 = 0; t1 = 0; t2 = 0;
    for (int c = 0; c < 3 * PER * B; c++) begin
      step();
      checks++; if (led !== exp_led) begin errors++; $display("FAIL blink_led n=%0d got %b exp %b", n, led, exp_led); end
      if (led[7] !== prev) begin
        if (tog == 0) t0 = n; else if (tog == 1) t1 = n; else t2 = n;
        tog++;
        prev = led[7];
      end
    end
    checks++; if (tog !== 3) begin errors++; $display("FAIL blink_toggles got %0d exp 3", tog); end
    checks++; if (t1 - t0 !== PER * B || t2 - t1 !== PER * B) begin
      errors++; $display("FAIL blink_spacing got %0d %0d exp %0d", t1 - t0, t2 - t1, PER * B);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_idx   = 3'($urandom_range(0, 7));
      cfg_mode  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       cfg_duty = 8'd0;
        1:       cfg_duty = 8'd255;
        default: cfg_duty = 8'($urandom_range(0, 255));
      endcase
      step();
      checks++; if (led !== exp_led) begin errors++; $display("FAIL rand_led n=%0d got %b exp %b", n, led, exp_led); end
      checks++; if (cfg_ready !== m_ready) begin errors++; $display("FAIL rand_ready n=%0d got %b exp %b", n, cfg_ready, m_ready); end
      checks++; if (pwm_wrap !== exp_wrap) begin errors++; $display("FAIL rand_wrap n=%0d got %b exp %b", n, pwm_wrap, exp_wrap); end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_on_write();
    test_fade();
    test_pwm64();
    test_duty_limits();
    test_wrap_write();
    test_blink();
    test_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog timeout at n=%0d", n);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
